// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and state encoding for the N-to-1 stream mux
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux_n_to_1_if.sv
// rtl/stream_mux_n_to_1_if.sv - producer/consumer bundle of the N-to-1 stream mux (Last ports with STREAM_MUX_PACKET_LOCK_EN)
interface stream_mux_n_to_1_if #(
  parameter int N_BITS     = 8,
  parameter int N_CHANNELS = 4
);

  localparam int SEL_WIDTH = $clog2(N_CHANNELS);

  logic                           Mode;
  logic [SEL_WIDTH-1:0]           Selector;
  logic [N_CHANNELS*N_BITS-1:0]   Data_In;
  logic [N_CHANNELS-1:0]          Valid_In;
  logic [N_CHANNELS-1:0]          Ready_In;
  logic [N_BITS-1:0]              Mux_Output;
  logic                           Valid_Out;
  logic                           Ready_Out;
  logic [SEL_WIDTH-1:0]           Grant_Channel;
`ifdef STREAM_MUX_PACKET_LOCK_EN
  logic [N_CHANNELS-1:0]          Last_In;
  logic                           Last_Out;

  modport slave (
    input  Mode, Selector, Data_In, Valid_In, Ready_Out, Last_In,
    output Ready_In, Mux_Output, Valid_Out, Grant_Channel, Last_Out
  );

  modport master (
    output Mode, Selector, Data_In, Valid_In, Ready_Out, Last_In,
    input  Ready_In, Mux_Output, Valid_Out, Grant_Channel, Last_Out
  );
`else
  modport slave (
    input  Mode, Selector, Data_In, Valid_In, Ready_Out,
    output Ready_In, Mux_Output, Valid_Out, Grant_Channel
  );

  modport master (
    output Mode, Selector, Data_In, Valid_In, Ready_Out,
    input  Ready_In, Mux_Output, Valid_Out, Grant_Channel
  );
`endif

endinterface

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - combinational round-robin pick: first request above ptr, wrapping
module round_robin_arbiter #(
  parameter int N_CHANNELS = 4,
  parameter int SEL_WIDTH  = $clog2(N_CHANNELS)
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  output logic [SEL_WIDTH-1:0]  grant,
  output logic                  grant_valid
);

  always_comb begin
    int                   idx;
    logic [SEL_WIDTH-1:0] idx_s;
    idx         = 0;
    idx_s       = '0;
    grant       = '0;
    grant_valid = 1'b0;
    // Walk from farthest to nearest so the channel closest above ptr wins last.
    for (int i = N_CHANNELS; i >= 1; i--) begin
      idx   = (int'(ptr) + i) % N_CHANNELS;
      idx_s = SEL_WIDTH'(idx);
      if (req[idx_s]) begin
        grant       = idx_s;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// rtl/stream_mux_n_to_1.sv - registered N-to-1 stream mux, fixed or round-robin select (packet lock with STREAM_MUX_PACKET_LOCK_EN)
module stream_mux_n_to_1
  import stream_mux_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int N_CHANNELS = 4
) (
  input logic                clk,
  input logic                reset,
  stream_mux_n_to_1_if.slave bus
);

  localparam int SEL_WIDTH = $clog2(N_CHANNELS);

  state_t               state, state_nxt;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] rr_grant;
  logic                 rr_valid;
  logic                 sel_valid;
  logic [SEL_WIDTH-1:0] cand;
  logic                 cand_valid;
  logic [N_BITS-1:0]    cand_data;
  logic                 out_free;
  logic                 accept;
  logic [N_BITS-1:0]    data_q;
  logic [SEL_WIDTH-1:0] grant_q;

`ifdef STREAM_MUX_PACKET_LOCK_EN
  logic                 lock_q;
  logic [SEL_WIDTH-1:0] lock_ch;
  logic                 lock_valid;
  logic                 cand_last;
  logic                 last_q;
`endif

  round_robin_arbiter #(
    .N_CHANNELS (N_CHANNELS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_arb (
    .req         (bus.Valid_In),
    .ptr         (rr_ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // An out-of-range Selector matches no channel, so it never yields a candidate.
  always_comb begin
    sel_valid = 1'b0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    lock_valid = 1'b0;
`endif
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (SEL_WIDTH'(i) == bus.Selector) sel_valid = bus.Valid_In[i];
`ifdef STREAM_MUX_PACKET_LOCK_EN
      if (SEL_WIDTH'(i) == lock_ch) lock_valid = bus.Valid_In[i];
`endif
    end

    if (bus.Mode == MODE_RR) begin
      cand       = rr_grant;
      cand_valid = rr_valid;
    end else begin
      cand       = bus.Selector;
      cand_valid = sel_valid;
    end

`ifdef STREAM_MUX_PACKET_LOCK_EN
    if (lock_q) begin
      cand       = lock_ch;
      cand_valid = lock_valid;
    end
`endif
  end

  assign out_free = reset & ((state == ST_EMPTY) | bus.Ready_Out);
  assign accept   = out_free & cand_valid;

  always_comb begin
    cand_data    = '0;
    bus.Ready_In = '0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    cand_last    = 1'b0;
`endif
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (SEL_WIDTH'(i) == cand) begin
        cand_data       = bus.Data_In[i*N_BITS +: N_BITS];
        bus.Ready_In[i] = accept;
`ifdef STREAM_MUX_PACKET_LOCK_EN
        cand_last       = bus.Last_In[i];
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (!accept && bus.Ready_Out) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_EMPTY;
      data_q  <= '0;
      grant_q <= '0;
      rr_ptr  <= SEL_WIDTH'(N_CHANNELS - 1);
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_q  <= cand_data;
        grant_q <= cand;
        if (bus.Mode == MODE_RR) rr_ptr <= cand;
      end
    end
  end

`ifdef STREAM_MUX_PACKET_LOCK_EN
  // A beat without Last pins arbitration to its channel until the packet ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      lock_q  <= !cand_last;
      lock_ch <= cand;
      last_q  <= cand_last;
    end
  end

  assign bus.Last_Out = last_q;
`endif

  assign bus.Valid_Out     = (state == ST_FULL);
  assign bus.Mux_Output    = data_q;
  assign bus.Grant_Channel = grant_q;

endmodule

// File: doc/stream_mux_n_to_1.md
Name: stream_mux_n_to_1

Overview:
- Registered N-to-1 stream multiplexer with per-channel valid/ready handshake; the successor to the combinational 2:1 data mux.
- Parametrised in data width and channel count.
- Two select modes: external Selector (fixed) or internal round-robin arbitration.
- Sits between multiple producers and a single consumer; one output register gives 1-cycle latency and full-throughput back-to-back transfers.

Parameters:
- N_BITS, 8, data width per channel.
- N_CHANNELS, 4, number of input channels (>=2).
- SEL_WIDTH, $clog2(N_CHANNELS), derived (localparam); width of Selector and Grant_Channel.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Mode  input  1  0 = fixed select via Selector; 1 = round-robin.
- Selector  input  SEL_WIDTH  channel index used when Mode=0.
- Data_In  input  N_CHANNELS*N_BITS  flat input bus; channel i occupies bits [i*N_BITS +: N_BITS].
- Valid_In  input  N_CHANNELS  per-channel valid.
- Ready_In  output  N_CHANNELS  per-channel ready, one-hot or zero.
- Mux_Output  output  N_BITS  registered selected data.
- Valid_Out  output  1  output holds a valid beat.
- Ready_Out  input  1  consumer accepts the beat.
- Grant_Channel  output  SEL_WIDTH  index of the channel whose beat is in the output register.

Behaviour:
- Reset (reset=0 at clk edge):
  - Valid_Out=0, Mux_Output=0, Grant_Channel=0.
  - RR pointer=N_CHANNELS-1, so channel 0 has first priority.
  - Reset mid-transfer drops the held beat.
- Output register is a 2-state FSM:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on Valid_Out&Ready_Out with no new accept.
  - FULL -> FULL on simultaneous drain+accept.
- out_free = !Valid_Out | Ready_Out (combinational pass-through ready; no skid buffer).
- Candidate selection, combinational:
  - Mode=0: cand=Selector, valid only if Selector<N_CHANNELS and Valid_In[Selector]=1.
  - Mode=1: first i with Valid_In[i]=1, searching from pointer+1 upward with wrap-around modulo N_CHANNELS.
- Ready_In[i]=out_free & cand_valid & (i==cand). At most one bit set. Ready_In is all-zero when no candidate.
- Accept = a handshake on the candidate channel. On accept, next edge:
  - Mux_Output<=Data_In[cand]
  - Grant_Channel<=cand
  - Valid_Out<=1
  - Mode=1 only: pointer<=cand
- Latency: input handshake at edge k -> Valid_Out high after edge k; throughput 1 beat/cycle while Ready_Out=1.
- While Valid_Out=1 & Ready_Out=0, Mux_Output and Grant_Channel hold stable (AXI-stream rule).
- Out-of-range Selector (>=N_CHANNELS): no grant, all Ready_In=0, no error flag.
- Mode or Selector change: affects only the next arbitration; the held beat is untouched. The RR pointer is not updated in Mode=0.
- Producers must hold Data_In/Valid_In until handshake. Ready_In does not depend on the same channel's Valid_In except through cand.

Optional Feature:
- Macro: STREAM_MUX_PACKET_LOCK_EN.
- Defined:
  - Adds ports Last_In (input, N_CHANNELS) and Last_Out (output, 1, reset 0, registered with the data).
  - After accepting a beat with Last_In[cand]=0, the grant locks to that channel in both modes, ignoring Selector/pointer.
  - The lock releases after a beat with Last=1 is accepted.
  - Reset clears the lock.
- Undefined: no Last ports; arbitration is per beat.

Decomposition:
- Package stream_mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - State encoding ST_EMPTY/ST_FULL.
- Sub-module round_robin_arbiter:
  - Parameter N_CHANNELS.
  - Inputs: request vector, pointer.
  - Outputs: grant index, grant_valid.
  - Purely combinational; the pointer register stays in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all Valid_In=1 -> Valid_Out=0, Mux_Output=0, Grant_Channel=0, Ready_In=0 after the edge.
- Fixed mode:
  - Stimulus: N_CHANNELS=4, Mode=0, Selector=2, Valid_In=4'b1111, Data_In ch2=0xA5, Ready_Out=1.
  - Response: Ready_In=4'b0100; next cycle Mux_Output=0xA5, Grant_Channel=2, Valid_Out=1.
- Round-robin:
  - Stimulus: Mode=1, all channels valid continuously, Ready_Out=1.
  - Response: Grant_Channel sequence 0,1,2,3,0 on consecutive cycles.
  - With only ch1, ch3 valid -> alternating 1,3,1.
- Backpressure: Ready_Out=0 for 3 cycles with output FULL -> Mux_Output stable, all Ready_In=0; Ready_Out=1 -> drain and new accept in the same cycle.
- Out-of-range: N_CHANNELS=3, Mode=0, Selector=3 -> Ready_In=0, Valid_Out stays 0.
- Packet lock (STREAM_MUX_PACKET_LOCK_EN):
  - Stimulus: Mode=1, ch0 sends 3 beats with Last on the third while ch1 is valid.
  - Response: Grant_Channel=0,0,0 then 1; Last_Out=1 only on the third beat.
